// File: rtl/iq_mod.sv
// iq_mod: transmit-side quadrature upconverter feeding the DAC path.
//
// Baseband I/Q samples enter through a valid/ready handshake into a small FIFO.
// Once the FIFO holds PRIME_LEVEL samples and enable is high, the block streams:
// every DAC_DIV clocks one sample is popped, mixed with a 4-phase fs/4 LO and
// registered onto I_IF/Q_IF together with a one-cycle dac_strobe.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   enable                stream enable (low in RUN -> DRAIN)
//   bb_valid, bb_ready    baseband handshake; bb_ready = FIFO not full
//   I_BB, Q_BB            signed baseband sample
//   dac_strobe            one-cycle pulse, I_IF/Q_IF new this cycle
//   I_IF, Q_IF            signed IF sample, registered
//   underrun              pulses with dac_strobe when a RUN tick finds the FIFO empty
//   busy                  high in RUN or DRAIN
//   sideband              (only with IQ_MOD_SIDEBAND_EN) 1 = LO phase runs 0,3,2,1
//
// Optional feature macro: IQ_MOD_SIDEBAND_EN adds the sideband input port.
module iq_mod #(
  parameter int unsigned W           = 5,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PRIME_LEVEL = 2,
  parameter int unsigned DAC_DIV     = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic         bb_valid,
  output logic         bb_ready,
  input  logic [W-1:0] I_BB,
  input  logic [W-1:0] Q_BB,
`ifdef IQ_MOD_SIDEBAND_EN
  input  logic         sideband,
`endif
  output logic         dac_strobe,
  output logic [W-1:0] I_IF,
  output logic [W-1:0] Q_IF,
  output logic         underrun,
  output logic         busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DW = (DAC_DIV > 1) ? $clog2(DAC_DIV) : 1;

  localparam logic [CW-1:0] DepthC  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PrimeC  = CW'(PRIME_LEVEL);
  localparam logic [DW-1:0] DivLast = DW'(DAC_DIV - 1);
  localparam logic [W-1:0]  MinVal  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MaxVal  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      phase_q, phase_d, phase_step;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [W-1:0]    mem_i_q [FIFO_DEPTH];
  logic [W-1:0]    mem_q_q [FIFO_DEPTH];
  logic [W-1:0]    i_if_q, i_if_d, q_if_q, q_if_d;
  logic            strobe_q, strobe_d, underrun_q, underrun_d;
  logic            push, pop, tick, empty;
  logic [W-1:0]    head_i, head_q, mix_i, mix_q;

  // Negation that clamps the most negative code to the most positive one.
  function automatic logic [W-1:0] sneg(input logic [W-1:0] x);
    return (x == MinVal) ? MaxVal : (~x + 1'b1);
  endfunction

  assign bb_ready   = (count_q < DepthC);
  assign push       = bb_valid && bb_ready;
  assign empty      = (count_q == '0);
  assign tick       = (state_q != StIdle) && (div_q == DivLast);
  assign busy       = (state_q != StIdle);
  assign dac_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign I_IF       = i_if_q;
  assign Q_IF       = q_if_q;

`ifdef IQ_MOD_SIDEBAND_EN
  assign phase_step = sideband ? (phase_q - 2'd1) : (phase_q + 2'd1);
`else
  assign phase_step = phase_q + 2'd1;
`endif

  // LO mixing of the FIFO head; LO phases are multiples of 90 degrees.
  always_comb begin
    head_i = mem_i_q[rd_ptr_q];
    head_q = mem_q_q[rd_ptr_q];
    mix_i  = head_i;
    mix_q  = head_q;
    unique case (phase_q)
      2'd0: begin mix_i = head_i;       mix_q = head_q;       end
      2'd1: begin mix_i = sneg(head_q); mix_q = head_i;       end
      2'd2: begin mix_i = sneg(head_i); mix_q = sneg(head_q); end
      2'd3: begin mix_i = head_q;       mix_q = sneg(head_i); end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    phase_d    = phase_q;
    i_if_d     = i_if_q;
    q_if_d     = q_if_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d   = '0;
        phase_d = '0;
        i_if_d  = '0;
        q_if_d  = '0;
        if (enable && (count_q >= PrimeC)) state_d = StRun;
      end
      StRun, StDrain: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (state_q == StRun && !enable)  state_d = StDrain;
        if (state_q == StDrain && enable) state_d = StRun;
        if (tick) begin
          strobe_d = 1'b1;
          phase_d  = phase_step;
          if (!empty) begin
            pop    = 1'b1;
            i_if_d = mix_i;
            q_if_d = mix_q;
          end else begin
            // A same-cycle push is not visible here; it stays queued.
            i_if_d = '0;
            q_if_d = '0;
            if (state_q == StRun) begin
              underrun_d = 1'b1;
            end else if (!enable) begin
              state_d = StIdle;
              phase_d = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      div_q      <= '0;
      phase_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      i_if_q     <= '0;
      q_if_q     <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      i_if_q     <= i_if_d;
      q_if_q     <= q_if_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i_q[wr_ptr_q] <= I_BB;
      mem_q_q[wr_ptr_q] <= Q_BB;
    end
  end

endmodule
